laser_period_gen: RTL and testbench

//  Laser repetition-rate generator, successor to the fixed 60-slot dither controller.

---
 rtl/laser_period_gen.sv | 124 ++++++++++++
 tb/tb_laser_period_gen.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_period_gen.sv
// Laser repetition-rate generator: base period plus a per-period dither offset.
// `LASER_DITHER_EN builds the slot table, seq_load, seq_idx and cur_ofs.
module laser_period_gen #(
    parameter int BASIC_NUM  = 120,
    parameter int SEQ_DEPTH  = 60,
    parameter int SLOT_W     = 4,
    parameter int OFS_W      = 3,
    parameter int CHANGE_POS = 60,
    // slot k sits at bits [k*SLOT_W +: SLOT_W]: slots 0-11 hold 0, 12-23 hold 1, ...
    parameter logic [SEQ_DEPTH*SLOT_W-1:0] RST_SEQ = {
        {12{4'd4}}, {12{4'd3}}, {12{4'd2}}, {12{4'd1}}, {12{4'd0}}},
    parameter int BURST_W    = 16,
    localparam int IDX_W     = $clog2(SEQ_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        laser_enable,
    input  logic [SEQ_DEPTH*SLOT_W-1:0] seq_data,
    input  logic                        seq_load,
    input  logic [BURST_W-1:0]          burst_len,
    output logic                        send_en,
    output logic                        change_flag,
    output logic                        busy,
    output logic                        burst_done,
    output logic [IDX_W-1:0]            seq_idx,
    output logic [OFS_W-1:0]            cur_ofs
);

    localparam int CNT_W = 16;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        BASIC  = 4'b0010,
        OFFSET = 4'b0100,
        DONE   = 4'b1000
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] shots;
    logic [BURST_W:0]   shots_inc;
    logic               start;
    logic               fire;
    logic               last;

    assign start     = (state == IDLE) && laser_enable;
    assign fire      = (state == OFFSET) && (cnt == CNT_W'(cur_ofs));
    assign shots_inc = {1'b0, shots} + (BURST_W+1)'(1);
    // a burst length already reached (or lowered below the count) ends at this shot
    assign last      = (burst_len != '0) && (shots_inc >= {1'b0, burst_len});

    assign send_en     = fire;
    assign change_flag = (state == BASIC) && (cnt == CNT_W'(CHANGE_POS));
    assign busy        = (state == BASIC) || (state == OFFSET);
    assign burst_done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (laser_enable) state_nxt = BASIC;
            BASIC:   if (cnt == CNT_W'(BASIC_NUM)) state_nxt = OFFSET;
            OFFSET:  if (fire) state_nxt = last ? DONE : IDLE;
            DONE:    if (!laser_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shots <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
            if (fire)
                shots <= shots_inc[BURST_W-1:0];
            else if ((state == DONE) && !laser_enable)
                shots <= '0;
        end
    end

`ifdef LASER_DITHER_EN
    logic [SEQ_DEPTH*SLOT_W-1:0] tbl;
    logic [IDX_W-1:0]            idx;
    logic [OFS_W-1:0]            ofs;
    logic [SLOT_W-1:0]           slot_new;
    logic [SLOT_W-1:0]           slot_cur;
    logic                        unused;

    assign slot_new = seq_data[SLOT_W-1:0];
    assign slot_cur = tbl[idx*SLOT_W +: SLOT_W];
    assign unused   = ^{slot_new, slot_cur};

    // a load coinciding with period start feeds new slot 0 straight through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= RST_SEQ;
            idx <= '0;
            ofs <= '0;
        end else begin
            if (seq_load)
                tbl <= seq_data;
            if (start)
                ofs <= seq_load ? slot_new[OFS_W-1:0] : slot_cur[OFS_W-1:0];
            if (seq_load)
                idx <= start ? IDX_W'(1) : '0;
            else if (start)
                idx <= (idx == IDX_W'(SEQ_DEPTH-1)) ? '0 : idx + IDX_W'(1);
        end
    end

    assign cur_ofs = ofs;
    assign seq_idx = idx;
`else
    logic unused;

    assign unused  = ^{seq_data, seq_load};
    assign cur_ofs = '0;
    assign seq_idx = '0;
`endif

endmodule

// File: tb/tb_laser_period_gen.sv
// Self-checking bench for laser_period_gen against a period-level timing model.
// Expected offsets follow `LASER_DITHER_EN the same way the design build does.
module tb_laser_period_gen;

    localparam int DEPTH = 60;
    localparam int SW    = 4;
    localparam int TW    = DEPTH*SW;
`ifdef LASER_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          laser_enable = 1'b0;
    logic          seq_load = 1'b0;
    logic [TW-1:0] seq_data = '0;
    logic [15:0]   burst_len = '0;
    logic          send_en;
    logic          change_flag;
    logic          busy;
    logic          burst_done;
    logic [5:0]    seq_idx;
    logic [2:0]    cur_ofs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int send_q[$];
    int chg_q[$];
    int mtbl[DEPTH];
    int midx;

    laser_period_gen #(.RST_SEQ('0)) dut (
        .clk(clk), .rst_n(rst_n), .laser_enable(laser_enable),
        .seq_data(seq_data), .seq_load(seq_load), .burst_len(burst_len),
        .send_en(send_en), .change_flag(change_flag), .busy(busy),
        .burst_done(burst_done), .seq_idx(seq_idx), .cur_ofs(cur_ofs)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (send_en) send_q.push_back(cyc);
        if (change_flag) chg_q.push_back(cyc);
    end

    // reference model: table of slot values and the next slot to use
    function automatic int ofs_of(input int v);
        return DITHER ? (v & 7) : 0;
    endfunction

    function automatic void model_reset();
        foreach (mtbl[i]) mtbl[i] = 0;
        midx = 0;
    endfunction

    function automatic void model_load(input logic [TW-1:0] d);
        if (DITHER) begin
            for (int i = 0; i < DEPTH; i++) mtbl[i] = int'(d[i*SW +: SW]);
            midx = 0;
        end
    endfunction

    function automatic int model_next();
        int o;
        o = ofs_of(mtbl[midx]);
        midx = (midx + 1) % DEPTH;
        return o;
    endfunction

    function automatic int exp_idx();
        return DITHER ? midx : 0;
    endfunction

    function automatic logic [TW-1:0] rand_table(input bit ramp);
        logic [TW-1:0] d;
        logic [3:0] s;
        d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            s = 4'($urandom_range(0, 15));
            if (ramp && i < 5) s = {s[3], 3'(i)};
            d[i*SW +: SW] = s;
        end
        return d;
    endfunction

    task automatic do_reset();
        laser_enable = 1'b0;
        seq_load = 1'b0;
        burst_len = '0;
        seq_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        send_q.delete();
        chg_q.delete();
        model_reset();
    endtask

    task automatic wait_sends(input int n, input int budget, output bit ok);
        ok = 1'b1;
        while (send_q.size() < n) begin
            if (budget <= 0) begin
                ok = 1'b0;
                return;
            end
            @(negedge clk); #1;
            budget--;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic timeout(input string name, input int got, input int want);
        errors++;
        $display("FAIL %s timeout: got %0d pulses, expected %0d", name, got, want);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({send_en, change_flag, busy, burst_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {send_en, change_flag, busy, burst_done});
        end
        checks++;
        if (seq_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_seq_idx: got %0d expected 0", seq_idx);
        end
        checks++;
        if (cur_ofs !== 3'd0) begin
            errors++;
            $display("FAIL reset_cur_ofs: got %0d expected 0", cur_ofs);
        end
    endtask

    task automatic test_continuous();
        int e[4];
        int o[4];
        int k;
        bit ok;
        do_reset();
        k = cyc;
        laser_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            o[i] = model_next();
            if (i == 0) e[i] = k + 122 + o[i];
            else e[i] = e[i-1] + 123 + o[i];
        end
        wait_sends(4, 700, ok);
        if (!ok) begin
            timeout("cont", send_q.size(), 4);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (send_q[i] !== e[i]) begin
                errors++;
                $display("FAIL cont_send[%0d]: got cycle %0d expected %0d",
                         i, send_q[i], e[i]);
            end
            checks++;
            if (chg_q.size() <= i || chg_q[i] !== e[i] - 61 - o[i]) begin
                errors++;
                $display("FAIL cont_change[%0d]: got %0d entries expected cycle %0d",
                         i, chg_q.size(), e[i] - 61 - o[i]);
            end
        end
        checks++;
        if (seq_idx !== 6'(exp_idx())) begin
            errors++;
            $display("FAIL cont_seq_idx: got %0d expected %0d", seq_idx, exp_idx());
        end
        laser_enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_dither_table();
        int o[65];
        int k;
        int d;
        bit ok;
        logic [TW-1:0] t;
        do_reset();
        t = rand_table(1'b1);
        k = cyc;
        seq_data = t;
        seq_load = 1'b1;
        laser_enable = 1'b1;
        model_load(t);
        for (int i = 0; i < 65; i++) o[i] = model_next();
        @(negedge clk); #1;
        seq_load = 1'b0;
        seq_data = rand_table(1'b0);
        wait_sends(65, 65 * 135, ok);
        if (!ok) begin
            timeout("dither", send_q.size(), 65);
            return;
        end
        checks++;
        if (send_q[0] !== k + 122 + o[0]) begin
            errors++;
            $display("FAIL dither_first: got cycle %0d expected %0d",
                     send_q[0], k + 122 + o[0]);
        end
        for (int i = 1; i < 65; i++) begin
            d = send_q[i] - send_q[i-1];
            checks++;
            if (d !== 123 + o[i]) begin
                errors++;
                $display("FAIL dither_interval[%0d]: got %0d expected %0d",
                         i, d, 123 + o[i]);
            end
        end
        checks++;
        if (seq_idx !== 6'(exp_idx())) begin
            errors++;
            $display("FAIL dither_wrap_idx: got %0d expected %0d", seq_idx, exp_idx());
        end
        checks++;
        if (cur_ofs !== 3'(o[64])) begin
            errors++;
            $display("FAIL dither_cur_ofs: got %0d expected %0d", cur_ofs, o[64]);
        end
        laser_enable = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_load_mid_offset();
        int e[6];
        int o[6];
        int k;
        int s3;
        bit ok;
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        do_reset();
        a = rand_table(1'b1);
        b = rand_table(1'b0);
        k = cyc;
        seq_data = a;
        seq_load = 1'b1;
        laser_enable = 1'b1;
        model_load(a);
        for (int i = 0; i < 5; i++) o[i] = model_next();
        model_load(b);
        o[5] = model_next();
        e[0] = k + 122 + o[0];
        for (int i = 1; i < 6; i++) e[i] = e[i-1] + 123 + o[i];
        @(negedge clk); #1;
        seq_load = 1'b0;
        wait_sends(4, 700, ok);
        if (!ok) begin
            timeout("midload", send_q.size(), 4);
            return;
        end
        s3 = send_q[3];
        wait_until(s3 + 124);
        seq_data = b;
        seq_load = 1'b1;
        @(negedge clk); #1;
        seq_load = 1'b0;
        checks++;
        if (cur_ofs !== 3'(o[4])) begin
            errors++;
            $display("FAIL midload_cur_ofs: got %0d expected %0d", cur_ofs, o[4]);
        end
        wait_sends(6, 400, ok);
        if (!ok) begin
            timeout("midload", send_q.size(), 6);
            return;
        end
        for (int i = 4; i < 6; i++) begin
            checks++;
            if (send_q[i] !== e[i]) begin
                errors++;
                $display("FAIL midload_send[%0d]: got cycle %0d expected %0d",
                         i, send_q[i], e[i]);
            end
        end
        laser_enable = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_burst();
        int n;
        int k;
        int k2;
        bit ok;
        do_reset();
        n = $urandom_range(2, 4);
        burst_len = 16'(n);
        k = cyc;
        laser_enable = 1'b1;
        wait_sends(n, 150 * n, ok);
        if (!ok) begin
            timeout("burst", send_q.size(), n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (send_q[i] !== k + 122 + 123 * i) begin
                errors++;
                $display("FAIL burst_send[%0d]: got cycle %0d expected %0d",
                         i, send_q[i], k + 122 + 123 * i);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({burst_done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL burst_done_set: got done,busy=%b expected 10",
                     {burst_done, busy});
        end
        repeat (300) @(negedge clk);
        #1;
        checks++;
        if (send_q.size() !== n || burst_done !== 1'b1) begin
            errors++;
            $display("FAIL burst_hold: got %0d pulses done=%b expected %0d done=1",
                     send_q.size(), burst_done, n);
        end
        laser_enable = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (burst_done !== 1'b0) begin
            errors++;
            $display("FAIL burst_done_clear: got %b expected 0", burst_done);
        end
        k2 = cyc;
        laser_enable = 1'b1;
        wait_sends(2 * n, 150 * n, ok);
        if (!ok) begin
            timeout("burst_restart", send_q.size(), 2 * n);
            return;
        end
        checks++;
        if (send_q[2*n-1] !== k2 + 122 + 123 * (n - 1)) begin
            errors++;
            $display("FAIL burst_restart: got cycle %0d expected %0d",
                     send_q[2*n-1], k2 + 122 + 123 * (n - 1));
        end
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (send_q.size() !== 2 * n || burst_done !== 1'b1) begin
            errors++;
            $display("FAIL burst_restart_hold: got %0d pulses done=%b expected %0d done=1",
                     send_q.size(), burst_done, 2 * n);
        end
        laser_enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_burst_live();
        int k;
        bit ok;
        do_reset();
        k = cyc;
        laser_enable = 1'b1;
        wait_sends(2, 300, ok);
        if (!ok) begin
            timeout("live", send_q.size(), 2);
            return;
        end
        @(negedge clk); #1;
        burst_len = 16'($urandom_range(1, 2));
        wait_sends(3, 200, ok);
        if (!ok) begin
            timeout("live", send_q.size(), 3);
            return;
        end
        checks++;
        if (send_q[2] !== k + 122 + 246) begin
            errors++;
            $display("FAIL live_send: got cycle %0d expected %0d",
                     send_q[2], k + 122 + 246);
        end
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (send_q.size() !== 3 || burst_done !== 1'b1) begin
            errors++;
            $display("FAIL live_stop: got %0d pulses done=%b expected 3 done=1",
                     send_q.size(), burst_done);
        end
        laser_enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int k;
        int d;
        bit ok;
        do_reset();
        d = $urandom_range(2, 110);
        k = cyc;
        laser_enable = 1'b1;
        wait_until(k + d);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy_before: got %b expected 1", busy);
        end
        laser_enable = 1'b0;
        wait_sends(1, 200, ok);
        if (!ok) begin
            timeout("drop", send_q.size(), 1);
            return;
        end
        checks++;
        if (send_q[0] !== k + 122) begin
            errors++;
            $display("FAIL drop_send: got cycle %0d expected %0d", send_q[0], k + 122);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_busy_after: got %b expected 0", busy);
        end
        repeat (300) @(negedge clk);
        #1;
        checks++;
        if (send_q.size() !== 1) begin
            errors++;
            $display("FAIL drop_no_more: got %0d pulses expected 1", send_q.size());
        end
    endtask

    task automatic test_reset_mid_offset();
        int k;
        int o;
        logic [TW-1:0] t;
        do_reset();
        t = rand_table(1'b0);
        t[2:0] = 3'd7;
        k = cyc;
        seq_data = t;
        seq_load = 1'b1;
        laser_enable = 1'b1;
        model_load(t);
        o = model_next();
        @(negedge clk); #1;
        seq_load = 1'b0;
        wait_until(k + 121);
        checks++;
        if (busy !== 1'b1 || cur_ofs !== 3'(o)) begin
            errors++;
            $display("FAIL rstmid_pre: got busy=%b ofs=%0d expected busy=1 ofs=%0d",
                     busy, cur_ofs, o);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({send_en, change_flag, busy, burst_done} !== 4'b0 ||
            cur_ofs !== 3'd0 || seq_idx !== 6'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got flags=%b ofs=%0d idx=%0d expected all 0",
                     {send_en, change_flag, busy, burst_done}, cur_ofs, seq_idx);
        end
        laser_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (150) @(negedge clk);
        #1;
        checks++;
        if (send_q.size() !== 0) begin
            errors++;
            $display("FAIL rstmid_no_send: got %0d pulses expected 0", send_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_dither_table();
        test_load_mid_offset();
        test_burst();
        test_burst_live();
        test_enable_drop();
        test_reset_mid_offset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
